// File: rtl/interrupt_controller_seq.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller_seq
// Brief    : Sticky-pending, SR-masked interrupt/exception controller with
//            one-cycle jisr dispatch, ESR save and eret restore.
//            Optional vectored entry address under IC_VECTORED_EN.
// Revision : 1.0
// ============================================================================
module interrupt_controller_seq #(
    parameter int                   N_CAUSE   = 23,
    parameter logic [N_CAUSE-1:0]   MASKABLE  = 23'h60FFFE,
    parameter int                   IL_W      = 5,
    parameter logic [31:0]          VEC_BASE  = 32'h0000_0000,
    parameter int                   VEC_SHIFT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CAUSE-1:0] ca,
    input  logic               stall,
    input  logic               eret,
    input  logic               sr_we,
    input  logic [31:0]        sr_wdata,
    output logic [31:0]        sr,
    output logic [31:0]        esr,
    output logic [N_CAUSE-1:0] eca,
    output logic [IL_W-1:0]    il,
    output logic               jisr,
`ifdef IC_VECTORED_EN
    output logic [31:0]        vec_addr,
`endif
    output logic               in_isr
);

    localparam logic [31:0] C_MASK32 = 32'(MASKABLE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ISR  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [N_CAUSE-1:0] r_pend;
    logic [N_CAUSE-1:0] w_avail;
    logic [N_CAUSE-1:0] w_mca;
    logic [IL_W-1:0]    w_il;
    logic               w_dispatch;
    logic               w_eret_ok;

    // Same-cycle bypass lets a fresh cause dispatch on the edge it is sampled.
    always_comb begin
        w_avail = r_pend | ca;
        w_mca   = w_avail & (~MASKABLE | sr[N_CAUSE-1:0]);
        w_il    = '0;
        for (int i = N_CAUSE - 1; i >= 0; i--) begin
            if (w_mca[i]) begin
                w_il = IL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dispatch   = 1'b0;
        w_eret_ok    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stall && (|w_mca)) begin
                    w_dispatch   = 1'b1;
                    w_state_next = S_ISR;
                end
            end
            S_ISR: begin
                // Only unmaskable causes may nest; eret loses to such a dispatch.
                if (!stall && (|(w_mca & ~MASKABLE))) begin
                    w_dispatch = 1'b1;
                end else if (eret) begin
                    w_eret_ok    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            sr     <= '0;
            esr    <= '0;
            eca    <= '0;
            il     <= '0;
            jisr   <= 1'b0;
        end else begin
            jisr <= w_dispatch;
            if (w_dispatch) begin
                eca    <= w_mca;
                il     <= w_il;
                r_pend <= w_avail & ~w_mca;
                sr     <= sr & ~C_MASK32;
                if (r_state == S_IDLE) begin
                    esr <= sr;
                end
            end else begin
                r_pend <= w_avail;
                if (w_eret_ok) begin
                    sr <= esr;
                end else if (sr_we) begin
                    sr <= sr_wdata;
                end
            end
        end
    end

`ifdef IC_VECTORED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_addr <= VEC_BASE;
        end else if (w_dispatch) begin
            vec_addr <= VEC_BASE + (32'(w_il) << VEC_SHIFT);
        end
    end
`endif

    assign in_isr = (r_state == S_ISR);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller_seq
// Brief    : Scoreboard bench for interrupt_controller_seq; expected dispatches
//            are queued by the stimulus and popped by a jisr monitor.
// Revision : 1.0
// ============================================================================
module tb_interrupt_controller_seq;

    localparam logic [31:0] C_VEC_BASE = 32'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] ca;
    logic        stall;
    logic        eret;
    logic        sr_we;
    logic [31:0] sr_wdata;
    logic [31:0] sr;
    logic [31:0] esr;
    logic [22:0] eca;
    logic [4:0]  il;
    logic        jisr;
    logic        in_isr;
`ifdef IC_VECTORED_EN
    logic [31:0] vec_addr;
`endif

    typedef struct packed {
        logic [4:0]  il;
        logic [22:0] eca;
        logic [31:0] esr;
        logic [31:0] sr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    interrupt_controller_seq #(
        .VEC_BASE(C_VEC_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ca       (ca),
        .stall    (stall),
        .eret     (eret),
        .sr_we    (sr_we),
        .sr_wdata (sr_wdata),
        .sr       (sr),
        .esr      (esr),
        .eca      (eca),
        .il       (il),
        .jisr     (jisr),
`ifdef IC_VECTORED_EN
        .vec_addr (vec_addr),
`endif
        .in_isr   (in_isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_disp(input int idx, input logic [31:0] e_esr, input logic [31:0] e_sr);
        exp_t e;
        e.il  = 5'(idx);
        e.eca = 23'(1) << idx;
        e.esr = e_esr;
        e.sr  = e_sr;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && jisr === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_jisr", 64'(il), 64'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("il", 64'(il), 64'(e.il));
                chk("eca", 64'(eca), 64'(e.eca));
                chk("esr", 64'(esr), 64'(e.esr));
                chk("sr", 64'(sr), 64'(e.sr));
                chk("in_isr", 64'(in_isr), 64'h1);
`ifdef IC_VECTORED_EN
                chk("vec_addr", 64'(vec_addr), 64'(C_VEC_BASE + (32'(e.il) << 5)));
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; ca = '0; stall = 1'b0; eret = 1'b0; sr_we = 1'b0; sr_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_sr", 64'(sr), 0);
        chk("rst_esr", 64'(esr), 0);
        chk("rst_eca", 64'(eca), 0);
        chk("rst_il", 64'(il), 0);
        chk("rst_jisr", 64'(jisr), 0);
        chk("rst_in_isr", 64'(in_isr), 0);

        // Unmaskable cause with sr=0
        ca = 23'(1) << 16; expect_disp(16, 32'h0, 32'h0); tick(); ca = '0;
        tick();
        chk("t1_in_isr", 64'(in_isr), 1);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t1_eret_in_isr", 64'(in_isr), 0);

        // Two simultaneous maskable causes: lowest index wins, both captured
        sr_we = 1'b1; sr_wdata = 32'h6; tick(); sr_we = 1'b0;
        chk("t2_sr_write", 64'(sr), 64'h6);
        ca = 23'h6;
        begin
            exp_t e; e.il = 5'd1; e.eca = 23'h6; e.esr = 32'h6; e.sr = 32'h0; q.push_back(e);
        end
        tick(); ca = '0; tick();
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t2_sr_restored", 64'(sr), 64'h6);
        tick();

        // Masked cause stays pending until SR enables it
        sr_we = 1'b1; sr_wdata = 32'h0; tick(); sr_we = 1'b0;
        ca = 23'(1) << 5; tick(); ca = '0; tick(); tick();
        chk("t3_no_jisr_masked", 64'(in_isr), 0);
        sr_we = 1'b1; sr_wdata = 32'h20; tick(); sr_we = 1'b0;
        expect_disp(5, 32'h20, 32'h0); tick(); tick();
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t3_sr_restored", 64'(sr), 64'h20);

        // Masked cause pending in ISR, unmaskable nest, then eret releases it
        sr_we = 1'b1; sr_wdata = 32'h8; tick(); sr_we = 1'b0;
        ca = 23'(1) << 16; expect_disp(16, 32'h8, 32'h0); tick(); ca = '0; tick();
        ca = 23'(1) << 3; tick(); ca = '0; tick(); tick();
        ca = 23'h1; expect_disp(0, 32'h8, 32'h0); tick(); ca = '0; tick();
        chk("t4_esr_kept", 64'(esr), 64'h8);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t4_sr_after_eret", 64'(sr), 64'h8);
        expect_disp(3, 32'h8, 32'h0); tick(); tick();
        eret = 1'b1; tick(); eret = 1'b0;

        // Stall defers dispatch
        sr_we = 1'b1; sr_wdata = 32'h0; tick(); sr_we = 1'b0;
        stall = 1'b1; ca = 23'(1) << 17; tick(); ca = '0; tick(); tick();
        chk("t5_stall_no_isr", 64'(in_isr), 0);
        stall = 1'b0; expect_disp(17, 32'h0, 32'h0); tick(); tick();
        // eret beats sr_we on the same edge
        eret = 1'b1; sr_we = 1'b1; sr_wdata = 32'hABC; tick(); eret = 1'b0; sr_we = 1'b0;
        chk("t5_eret_over_srwe", 64'(sr), 64'h0);
        chk("t5_in_isr_clear", 64'(in_isr), 0);

        // eret in IDLE is ignored, so sr_we takes effect
        eret = 1'b1; sr_we = 1'b1; sr_wdata = 32'h10; tick(); eret = 1'b0; sr_we = 1'b0;
        chk("idle_eret_srwe", 64'(sr), 64'h10);

        // Dispatch beats sr_we on the same edge
        sr_we = 1'b1; sr_wdata = 32'h40; ca = 23'(1) << 18;
        expect_disp(18, 32'h10, 32'h0); tick(); ca = '0; sr_we = 1'b0; tick();

        // Async reset mid-ISR
        #2 reset = 1'b1; #1;
        chk("arst_sr", 64'(sr), 0);
        chk("arst_esr", 64'(esr), 0);
        chk("arst_eca", 64'(eca), 0);
        chk("arst_il", 64'(il), 0);
        chk("arst_in_isr", 64'(in_isr), 0);
        tick(); reset = 1'b0;
        ca = 23'h1; expect_disp(0, 32'h0, 32'h0); tick(); ca = '0;
        tick(); tick();

        chk("queue_drained", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
